pipelined_segment_adder: RTL and testbench



---
 rtl/pipelined_segment_adder_if.sv | 36 +++
 rtl/pipelined_segment_adder.sv | 116 +++++++++++
 tb/tb_pipelined_segment_adder.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_segment_adder_if.sv
// Operand/result handshake bundle for pipelined_segment_adder. Optional macro: ADDER_SUB_EN.
interface pipelined_segment_adder_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] N1;
    logic [N-1:0] N2;
    logic         cin;
`ifdef ADDER_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] St;
    logic         cout;
    logic         ovf;

    modport master (
        output in_valid, N1, N2, cin,
`ifdef ADDER_SUB_EN
        output sub,
`endif
        output out_ready,
        input  in_ready, out_valid, St, cout, ovf
    );

    modport slave (
        input  in_valid, N1, N2, cin,
`ifdef ADDER_SUB_EN
        input  sub,
`endif
        input  out_ready,
        output in_ready, out_valid, St, cout, ovf
    );
endinterface

// File: rtl/pipelined_segment_adder.sv
// N-bit adder built from SEG-bit ripple segments, one valid/ready pipeline stage per
// segment. Optional macro ADDER_SUB_EN adds a subtract mode (port sub).
module pipelined_segment_adder #(
    parameter int N   = 32,
    parameter int SEG = 8
) (
    input logic                      clk,
    input logic                      rst,
    pipelined_segment_adder_if.slave bus
);
    localparam int S = N / SEG;

    if ((N % SEG) != 0 || N < SEG) begin : g_param_check
        $error("pipelined_segment_adder: N (%0d) must be a nonzero multiple of SEG (%0d)", N, SEG);
    end

    for (genvar k = 0; k < S; k++) begin : g_stage
        // W is the number of operand bits not yet added when data enters stage k.
        localparam int W = N - k * SEG;

        logic [W-1:0]         aIn;
        logic [W-1:0]         bIn;
        logic                 cIn;
        logic                 vIn;
        logic [SEG-1:0]       segSum;
        logic                 carry_d;
        logic [(k+1)*SEG-1:0] sum_d;
        logic                 valid_q;
        logic                 carry_q;
        logic [(k+1)*SEG-1:0] sum_q;
        logic                 ready;

        if (k == 0) begin : g_head
`ifdef ADDER_SUB_EN
            // Subtraction is N1 + ~N2 + 1; the inverted operand bits carry the mode onward.
            assign bIn = bus.sub ? ~bus.N2 : bus.N2;
            assign cIn = bus.sub | bus.cin;
`else
            assign bIn = bus.N2;
            assign cIn = bus.cin;
`endif
            assign aIn   = bus.N1;
            assign vIn   = bus.in_valid;
            assign sum_d = segSum;
        end else begin : g_body
            assign aIn   = g_stage[k-1].g_rem.aRem_q;
            assign bIn   = g_stage[k-1].g_rem.bRem_q;
            assign cIn   = g_stage[k-1].carry_q;
            assign vIn   = g_stage[k-1].valid_q;
            assign sum_d = {segSum, g_stage[k-1].sum_q};
        end

        if (k == S - 1) begin : g_last_ready
            assign ready = !valid_q || bus.out_ready;
        end else begin : g_mid_ready
            assign ready = !valid_q || g_stage[k+1].ready;
        end

        always_comb begin
            logic c;
            c      = cIn;
            segSum = '0;
            for (int i = 0; i < SEG; i++) begin
                segSum[i] = aIn[i] ^ bIn[i] ^ c;
                c         = (aIn[i] & bIn[i]) | (c & (aIn[i] ^ bIn[i]));
            end
            carry_d = c;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (ready) begin
                valid_q <= vIn;
                if (vIn) begin
                    carry_q <= carry_d;
                    sum_q   <= sum_d;
                end
            end
        end

        if (k < S - 1) begin : g_rem
            logic [W-SEG-1:0] aRem_q;
            logic [W-SEG-1:0] bRem_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    aRem_q <= '0;
                    bRem_q <= '0;
                end else if (ready && vIn) begin
                    aRem_q <= aIn[W-1:SEG];
                    bRem_q <= bIn[W-1:SEG];
                end
            end
        end else begin : g_tail
            logic ovf_q;

            // Carry into the MSB is recovered from the MSB sum bit (s = a ^ b ^ cin).
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (ready && vIn) begin
                    ovf_q <= aIn[SEG-1] ^ bIn[SEG-1] ^ segSum[SEG-1] ^ carry_d;
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].ready;
    assign bus.out_valid = g_stage[S-1].valid_q;
    assign bus.St        = g_stage[S-1].sum_q;
    assign bus.cout      = g_stage[S-1].carry_q;
    assign bus.ovf       = g_stage[S-1].g_tail.ovf_q;
endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Self-checking bench: an 8-bit/4-bit-segment instance for latency, backpressure and
// reset cases, and a 32-bit/8-bit instance for directed and random traffic.
module tb_pipelined_segment_adder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    pipelined_segment_adder_if #(.N(8))  bus8 ();
    pipelined_segment_adder_if #(.N(32)) bus32 ();

    pipelined_segment_adder #(.N(8),  .SEG(4)) dut8  (.clk(clk), .rst(rst), .bus(bus8));
    pipelined_segment_adder #(.N(32), .SEG(8)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] st;
        logic       co;
        logic       ov;
    } vec8_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
    } op32_t;

    typedef struct {
        logic [31:0] st;
        logic        co;
        logic        ov;
    } res32_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        s;
        logic [31:0] st;
        logic        co;
        logic        ov;
    } vec32_t;

    op32_t  opQ[$];
    res32_t expQ[$];

    // Reference: exact integer arithmetic; overflow means the true signed result
    // does not fit in 32 bits.
    function automatic res32_t model32(input op32_t op);
        res32_t r;
        longint ua, ub, sa, sb, u, sres;
        ua = longint'(op.a);
        ub = longint'(op.b);
        sa = longint'($signed(op.a));
        sb = longint'($signed(op.b));
        if (op.s) begin
            u    = ua - ub;
            sres = sa - sb;
            r.co = (ua >= ub);
        end else begin
            u    = ua + ub + longint'(op.c);
            sres = sa + sb + longint'(op.c);
            r.co = u[32];
        end
        r.st = u[31:0];
        r.ov = (sres != longint'($signed(u[31:0])));
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        bus8.in_valid = v;
        bus8.N1       = a;
        bus8.N2       = b;
        bus8.cin      = c;
`ifdef ADDER_SUB_EN
        bus8.sub      = 1'b0;
`endif
    endtask

    // One isolated transaction on the 8-bit instance: result exactly two cycles later.
    task automatic sendOne8(input vec8_t v, input string tag);
        @(posedge clk); #1;
        applyStimulus(1'b1, v.a, v.b, v.c);
        @(negedge clk);
        checkOutput({tag, " in_ready"}, bus8.in_ready, 1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput({tag, " early"}, bus8.out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " valid"}, bus8.out_valid, 1);
        checkOutput({tag, " result"}, {bus8.cout, bus8.ovf, bus8.St}, {v.co, v.ov, v.st});
        @(posedge clk);
        @(negedge clk);
        checkOutput({tag, " single"}, bus8.out_valid, 0);
    endtask

    // Streams opQ into the 32-bit instance and compares each emitted result with expQ.
    task automatic runStream32(input int vPct, input int rPct, input int budget, input string tag);
        int          cyc;
        bit          offering;
        bit          holdPrev;
        logic [33:0] prevOut;
        op32_t       op;
        res32_t      e;
        cyc = 0;
        offering = 1'b0;
        holdPrev = 1'b0;
        prevOut = '0;
        while ((opQ.size() > 0 || expQ.size() > 0) && cyc < budget) begin
            @(posedge clk); #1;
            if (!offering && opQ.size() > 0 && $urandom_range(0, 99) < vPct) offering = 1'b1;
            bus32.in_valid = offering;
            if (offering) begin
                bus32.N1  = opQ[0].a;
                bus32.N2  = opQ[0].b;
                bus32.cin = opQ[0].c;
`ifdef ADDER_SUB_EN
                bus32.sub = opQ[0].s;
`endif
            end
            bus32.out_ready = ($urandom_range(0, 99) < rPct);
            @(negedge clk);
            if (holdPrev)
                checkOutput({tag, " hold"}, {bus32.out_valid, bus32.cout, bus32.ovf, bus32.St}, {1'b1, prevOut});
            if (bus32.in_valid && bus32.in_ready) begin
                op = opQ.pop_front();
                offering = 1'b0;
            end
            if (bus32.out_valid && bus32.out_ready) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s extra: got result 0x%0h, expected none", tag, bus32.St);
                end else begin
                    e = expQ.pop_front();
                    checkOutput({tag, " result"}, {bus32.cout, bus32.ovf, bus32.St}, {e.co, e.ov, e.st});
                end
            end
            holdPrev = bus32.out_valid && !bus32.out_ready;
            prevOut = {bus32.cout, bus32.ovf, bus32.St};
            cyc++;
        end
        bus32.in_valid = 1'b0;
        checkOutput({tag, " drained"}, opQ.size() + expQ.size(), 0);
        opQ.delete();
        expQ.delete();
        @(posedge clk); #1;
        bus32.out_ready = 1'b1;
        @(negedge clk);
        checkOutput({tag, " idle"}, bus32.out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec8_t       tab8[8];
        vec32_t      tab32[$];
        vec8_t       extra;
        op32_t       op;
        int          inIdx, outIdx, cyc, seen;
        bit          sawFull, holdPrev;
        logic [7:0]  prevSt;

        tab8[0] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tab8[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tab8[2] = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0};
        tab8[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tab8[4] = '{8'h55, 8'hAA, 1'b1, 8'h00, 1'b1, 1'b0};
        tab8[5] = '{8'h3C, 8'h4C, 1'b0, 8'h88, 1'b0, 1'b1};
        tab8[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tab8[7] = '{8'h7F, 8'h80, 1'b1, 8'h00, 1'b1, 1'b0};

        tab32.push_back(vec32_t'{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
        tab32.push_back(vec32_t'{32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1});
        tab32.push_back(vec32_t'{32'h12345678, 32'h11111111, 1'b1, 1'b0, 32'h2345678A, 1'b0, 1'b0});
        tab32.push_back(vec32_t'{32'h00FFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h01000000, 1'b0, 1'b0});
`ifdef ADDER_SUB_EN
        tab32.push_back(vec32_t'{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
        tab32.push_back(vec32_t'{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1});
        tab32.push_back(vec32_t'{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0});
`endif

        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        bus8.out_ready  = 1'b1;
        bus32.in_valid  = 1'b0;
        bus32.N1        = '0;
        bus32.N2        = '0;
        bus32.cin       = 1'b0;
`ifdef ADDER_SUB_EN
        bus32.sub       = 1'b0;
`endif
        bus32.out_ready = 1'b1;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset out_valid", bus8.out_valid, 0);
        checkOutput("reset St", bus8.St, 0);
        checkOutput("reset cout", bus8.cout, 0);
        checkOutput("reset ovf", bus8.ovf, 0);
        checkOutput("reset in_ready", bus8.in_ready, 1);
        checkOutput("reset out_valid32", bus32.out_valid, 0);
        checkOutput("reset in_ready32", bus32.in_ready, 1);

        for (int i = 0; i < 8; i++) sendOne8(tab8[i], $sformatf("vec8[%0d]", i));

        @(posedge clk); #1;
        applyStimulus(1'b1, 8'hFF, 8'h01, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h0F, 8'h01, 1'b1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("b2b first", {bus8.out_valid, bus8.cout, bus8.St}, {1'b1, 1'b1, 8'h00});
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b second", {bus8.out_valid, bus8.cout, bus8.St}, {1'b1, 1'b0, 8'h11});

        inIdx = 0;
        outIdx = 0;
        cyc = 0;
        sawFull = 1'b0;
        holdPrev = 1'b0;
        prevSt = '0;
        while (outIdx < 6 && cyc < 40) begin
            @(posedge clk); #1;
            applyStimulus(inIdx < 6, 8'(inIdx + 1), 8'h10, 1'b0);
            bus8.out_ready = !(cyc >= 3 && cyc <= 5);
            @(negedge clk);
            if (holdPrev)
                checkOutput($sformatf("bp hold c%0d", cyc), {bus8.out_valid, bus8.St}, {1'b1, prevSt});
            if (!bus8.in_ready) sawFull = 1'b1;
            if (bus8.in_valid && bus8.in_ready) inIdx++;
            if (bus8.out_valid && bus8.out_ready) begin
                checkOutput($sformatf("bp out%0d", outIdx), bus8.St, 8'h11 + 8'(outIdx));
                outIdx++;
            end
            holdPrev = bus8.out_valid && !bus8.out_ready;
            prevSt = bus8.St;
            cyc++;
        end
        checkOutput("bp count", outIdx, 6);
        checkOutput("bp in_ready low", sawFull, 1);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        bus8.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp no dup", bus8.out_valid, 0);

        bus8.out_ready = 1'b0;
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h21, 8'h01, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b1, 8'h22, 8'h01, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("pre-rst valid", bus8.out_valid, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        bus8.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst mid in_ready", bus8.in_ready, 1);
        checkOutput("rst mid St", bus8.St, 0);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus8.out_valid) seen++;
        end
        checkOutput("rst mid flush", seen, 0);
        extra = '{8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0};
        sendOne8(extra, "after rst");

        foreach (tab32[i]) begin
            opQ.push_back(op32_t'{tab32[i].a, tab32[i].b, tab32[i].c, tab32[i].s});
            expQ.push_back(res32_t'{tab32[i].st, tab32[i].co, tab32[i].ov});
        end
        runStream32(100, 100, 200, "dir32");
        foreach (tab32[i]) begin
            opQ.push_back(op32_t'{tab32[i].a, tab32[i].b, tab32[i].c, tab32[i].s});
            expQ.push_back(res32_t'{tab32[i].st, tab32[i].co, tab32[i].ov});
        end
        runStream32(50, 50, 400, "dir32hs");

        for (int i = 0; i < 10000; i++) begin
            op.a = $urandom;
            op.b = $urandom;
            if ($urandom_range(0, 7) == 0) op.b = ~op.a;
            op.c = 1'($urandom_range(0, 1));
`ifdef ADDER_SUB_EN
            op.s = 1'($urandom_range(0, 1));
`else
            op.s = 1'b0;
`endif
            opQ.push_back(op);
            expQ.push_back(model32(op));
        end
        runStream32(70, 70, 60000, "rand32");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
